seq_mult: RTL and testbench

Parametrised shift-add unsigned multiplier, split into a one-hot control unit and a datapath. It generalises the team's fixed three-state control logic:
- operand width is a parameter;
- an iteration counter sets the loop length;
- a start/busy/done handshake frames each operation;
- an optional early-exit mode shortens the loop.

It sits beside the lab ALU as the multi-cycle arithmetic unit.

---
 rtl/seq_mult_pkg.sv | 25 ++
 rtl/seq_mult_ctrl.sv | 60 ++++++
 rtl/seq_mult.sv | 109 ++++++++++
 tb/tb_seq_mult.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg
// Brief    : Shared one-hot state encoding for the shift-add multiplier.
// Revision : 1.0
// ============================================================================
package seq_mult_pkg;

   localparam int unsigned c_STATE_W = 4;

   // Bit positions within the one-hot state vector
   localparam int unsigned c_IDLE  = 0;
   localparam int unsigned c_ADD   = 1;
   localparam int unsigned c_SHIFT = 2;
   localparam int unsigned c_DONE  = 3;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE  = 4'b0001,
      ST_ADD   = 4'b0010,
      ST_SHIFT = 4'b0100,
      ST_DONE  = 4'b1000
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Brief    : One-hot control unit sequencing the ADD/SHIFT loop of seq_mult.
// Revision : 1.0
// ============================================================================
module seq_mult_ctrl
   import seq_mult_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 b0,
   input  logic                 last,
   input  logic                 early_zero,
   output logic [c_STATE_W-1:0] state,
   output logic                 load,
   output logic                 add_en,
   output logic                 shift_en
);

   state_t r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (early_zero)
                     r_state <= ST_DONE;
                  else if (b0)
                     r_state <= ST_ADD;
                  else
                     r_state <= ST_SHIFT;
               end
            end
            ST_ADD:   r_state <= ST_SHIFT;
            ST_SHIFT: begin
               if (last)
                  r_state <= ST_DONE;
               else if (b0)
                  r_state <= ST_ADD;
               else
                  r_state <= ST_SHIFT;
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign state    = r_state;
   assign load     = r_state[c_IDLE] & start;
   assign add_en   = r_state[c_ADD];
   assign shift_en = r_state[c_SHIFT];

endmodule
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult
// Brief    : Parametrised shift-add unsigned multiplier with start/busy/done.
// Revision : 1.0
// ============================================================================
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [c_STATE_W-1:0] state
);

   localparam int c_CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH:0]       r_acc;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   logic [c_STATE_W-1:0] w_state;
   logic                 w_load;
   logic                 w_add_en;
   logic                 w_shift_en;
   logic                 w_last;
   logic                 w_early_zero;
   logic                 w_b0;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_acc_sh;
   logic [WIDTH-1:0]     w_b_sh;
   logic [c_CNT_W-1:0]   w_cnt_sh;
   logic [WIDTH-1:0]     w_mask;
   logic [2*WIDTH-1:0]   w_product_sh;

   assign w_sum    = {1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_a};
   assign w_acc_sh = {1'b0, r_acc[WIDTH:1]};
   assign w_b_sh   = {r_acc[0], r_b[WIDTH-1:1]};
   assign w_cnt_sh = r_cnt - c_CNT_W'(1);

   // Low w_cnt_sh bits of the shifted B are multiplier bits not yet consumed
   assign w_mask = (WIDTH'(1) << w_cnt_sh) - WIDTH'(1);
   assign w_last = (r_cnt == c_CNT_W'(1)) ||
                   ((EARLY_EXIT != 0) && ((w_b_sh & w_mask) == '0));

   assign w_early_zero = (EARLY_EXIT != 0) && (b == '0);
   assign w_b0         = w_state[c_IDLE] ? b[0] : w_b_sh[0];

   // An early exit skips zero-only iterations; realign by the shifts left over
   assign w_product_sh = {w_acc_sh[WIDTH-1:0], w_b_sh} >> w_cnt_sh;

   seq_mult_ctrl u_ctrl (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .b0         (w_b0),
      .last       (w_last),
      .early_zero (w_early_zero),
      .state      (w_state),
      .load       (w_load),
      .add_en     (w_add_en),
      .shift_en   (w_shift_en)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         if (w_load) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= c_CNT_W'(WIDTH);
            if (w_early_zero)
               r_product <= '0;
         end
         if (w_add_en)
            r_acc <= w_sum;
         if (w_shift_en) begin
            r_acc <= w_acc_sh;
            r_b   <= w_b_sh;
            r_cnt <= w_cnt_sh;
            if (w_last)
               r_product <= w_product_sh;
         end
      end
   end

   assign state   = w_state;
   assign busy    = ~w_state[c_IDLE];
   assign done    = w_state[c_DONE];
   assign product = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult
// Brief    : Directed and randomised checks of seq_mult in both exit modes.
// Revision : 1.0
// ============================================================================
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        rst;
   logic        start0, start1;
   logic [7:0]  a0, b0, a1, b1;
   logic        busy0, done0, busy1, done1;
   logic [15:0] prod0, prod1;
   logic [3:0]  st0, st1;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(8), .EARLY_EXIT(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .product(prod0), .state(st0)
   );

   seq_mult #(.WIDTH(8), .EARLY_EXIT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .product(prod1), .state(st1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int lat_model(input logic [7:0] bv, input bit ee);
      int msb;
      msb = -1;
      for (int i = 0; i < 8; i++)
         if (bv[i]) msb = i;
      if (!ee)
         return 8 + $countones(bv) + 1;
      if (bv == 8'd0)
         return 1;
      return (msb + 1) + $countones(bv) + 1;
   endfunction

   // Cycle invariants: one-hot state, done only in DONE, busy outside IDLE
   always @(negedge clk) begin
      if (mon_en) begin
         check("onehot0", {31'd0, $onehot(st0)}, 32'd1);
         check("onehot1", {31'd0, $onehot(st1)}, 32'd1);
         check("done_in_done0", {31'd0, done0}, {31'd0, st0[3]});
         check("done_in_done1", {31'd0, done1}, {31'd0, st1[3]});
         check("busy_state0", {31'd0, busy0}, {31'd0, ~st0[0]});
         check("busy_state1", {31'd0, busy1}, {31'd0, ~st1[0]});
      end
   end

   task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [15:0] exp_p, input int exp_l0, input int exp_l1);
      int n, l0, l1;
      bit got0, got1;
      logic [15:0] p0, p1;
      n = 0; l0 = 0; l1 = 0; got0 = 1'b0; got1 = 1'b0; p0 = 'x; p1 = 'x;
      @(negedge clk);
      a0 = ta; b0 = tb; a1 = ta; b1 = tb;
      start0 = 1'b1; start1 = 1'b1;
      while (!(got0 && got1) && n < 40) begin
         @(posedge clk); #1;
         n++;
         start0 = 1'b0; start1 = 1'b0;
         if (!got0) begin
            if (done0) begin got0 = 1'b1; l0 = n; p0 = prod0; end
            else check({tag, "_busy0"}, {31'd0, busy0}, 32'd1);
         end
         if (!got1) begin
            if (done1) begin got1 = 1'b1; l1 = n; p1 = prod1; end
            else check({tag, "_busy1"}, {31'd0, busy1}, 32'd1);
         end
      end
      check({tag, "_prod0"}, {16'd0, p0}, {16'd0, exp_p});
      check({tag, "_lat0"}, l0, exp_l0);
      check({tag, "_prod1"}, {16'd0, p1}, {16'd0, exp_p});
      check({tag, "_lat1"}, l1, exp_l1);
      @(posedge clk); #1;
      check({tag, "_hold0"}, {16'd0, prod0}, {16'd0, exp_p});
      check({tag, "_hold1"}, {16'd0, prod1}, {16'd0, exp_p});
   endtask

   initial begin
      int n, seen;
      logic [7:0] ra, rb;

      rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("rst_state0", {28'd0, st0}, 32'd1);
      check("rst_state1", {28'd0, st1}, 32'd1);
      check("rst_busy0", {31'd0, busy0}, 32'd0);
      check("rst_done0", {31'd0, done0}, 32'd0);
      check("rst_prod0", {16'd0, prod0}, 32'd0);
      check("rst_prod1", {16'd0, prod1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("m13x11",   8'd13,  8'd11,  16'd143,   12, 8);
      run_op("m255x255", 8'd255, 8'd255, 16'd65025, 17, 17);
      run_op("m0x0",     8'd0,   8'd0,   16'd0,     9,  1);
      run_op("m200x3",   8'd200, 8'd3,   16'd600,   11, 5);
      run_op("m2x128",   8'd2,   8'd128, 16'd256,   10, 10);

      // start held high with changing operands while the first op runs
      @(negedge clk);
      a0 = 8'd13; b0 = 8'd11; start0 = 1'b1;
      @(posedge clk); #1;
      a0 = 8'd99; b0 = 8'd77;
      n = 1;
      while (!done0 && n < 40) begin @(posedge clk); #1; n++; end
      check("ign_lat", n, 12);
      check("ign_prod", {16'd0, prod0}, 32'd143);
      @(posedge clk); #1;
      check("ign_done_to_idle", {28'd0, st0}, 32'd1);
      check("ign_prod_held", {16'd0, prod0}, 32'd143);
      @(posedge clk); #1;
      check("retrig_busy", {31'd0, busy0}, 32'd1);
      start0 = 1'b0;
      n = 1;
      while (!done0 && n < 40) begin @(posedge clk); #1; n++; end
      check("retrig_lat", n, 13);
      check("retrig_prod", {16'd0, prod0}, 32'd7623);
      @(posedge clk); #1;

      // reset after 4 edges of a running operation
      @(negedge clk);
      a0 = 8'd255; b0 = 8'd255; a1 = 8'd255; b1 = 8'd255;
      start0 = 1'b1; start1 = 1'b1;
      repeat (4) begin @(posedge clk); #1; start0 = 1'b0; start1 = 1'b0; end
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_state0", {28'd0, st0}, 32'd1);
      check("midrst_busy0", {31'd0, busy0}, 32'd0);
      check("midrst_prod0", {16'd0, prod0}, 32'd0);
      check("midrst_state1", {28'd0, st1}, 32'd1);
      check("midrst_prod1", {16'd0, prod1}, 32'd0);
      @(negedge clk);
      start0 = 1'b1; a0 = 8'd5; b0 = 8'd5;
      @(posedge clk); #1;
      check("rst_beats_start", {28'd0, st0}, 32'd1);
      @(negedge clk);
      rst = 1'b0; start0 = 1'b0;
      seen = 0;
      repeat (20) begin @(posedge clk); #1; if (done0 || done1) seen++; end
      check("midrst_no_done", seen, 0);
      run_op("m7x6", 8'd7, 8'd6, 16'd42, 11, 6);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op("rnd", ra, rb, 16'(ra) * 16'(rb), lat_model(rb, 1'b0), lat_model(rb, 1'b1));
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
